// File: rtl/mem_access_unit_if.sv
// Memory bus between mem_access_unit (master) and a variable-latency memory (slave):
// level req held until a one-cycle ack, registered address/data/direction.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle MIPS datapath: strobe -> req/ack bus cycle, owns MDR.
// Optional MEM_ALIGN_CHECK_EN: reject misaligned word addresses with an err pulse, no bus cycle.
module mem_access_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] mdr,
   output logic              stall,
   output logic              err,
   mem_access_unit_if.master bus
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;

   logic              access;
   logic              misaligned;
   logic [ADDR_W-1:0] addr_word;
   logic              latch;
   logic              load_mdr;
   logic              fault;
   logic              cnt_clr;
   logic              cnt_inc;

   // Bus addresses are always word addresses; with the check enabled the low bits
   // are already zero whenever a bus cycle is actually started.
   assign addr_word = addr & ~ADDR_W'(3);

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = |addr[1:0];
`else
   assign misaligned = 1'b0;
`endif

   assign access = mem_read | mem_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      load_mdr  = 1'b0;
      fault     = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      stall     = access & (state != DONE);
      case (state)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  fault     = 1'b1;
                  state_nxt = DONE;
               end else begin
                  latch     = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            // An ack on the final allowed cycle still completes the access.
            if (bus.bus_ack) begin
               load_mdr  = ~we_q;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               fault     = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         mdr     <= '0;
         err     <= 1'b0;
         cnt     <= '0;
      end else begin
         err <= fault;
         if (latch) begin
            addr_q  <= addr_word;
            wdata_q <= wdata;
            we_q    <= mem_write;
         end
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
         if (load_mdr) mdr <= bus.bus_rdata;
      end
   end

   // bus_req decodes straight from the state register so reset drops it asynchronously.
   assign bus.bus_req   = (state == BUSY);
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner sequences, random accesses.
module tb_mem_access_unit;

   localparam int unsigned TO = 15;
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] addr, wdata;
   logic [31:0] mdr;
   logic        stall, err;

   mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .mdr       (mdr),
      .stall     (stall),
      .err       (err),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] mdr_model;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [31:0] wd;
      int          lat;       // BUSY cycle (1-based) carrying the ack; > TO means never
      logic [31:0] rdat;
      int          exp_stall; // cycles with stall high
      int          exp_req;   // cycles with bus_req high
      int          exp_err;   // err pulses
      logic [31:0] exp_mdr;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rd, bit wr, logic [31:0] a, logic [31:0] wd, int lat,
                               logic [31:0] rdat, int s, int r, int e, logic [31:0] m);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.lat = lat; v.rdat = rdat;
      v.exp_stall = s; v.exp_req = r; v.exp_err = e; v.exp_mdr = m;
      return v;
   endfunction

   // Outcome of one access from the behavioural rules alone.
   function automatic vec_t predict(bit rd, bit wr, logic [31:0] a, logic [31:0] wd, int lat,
                                    logic [31:0] rdat, logic [31:0] prev);
      logic [1:0] low;
      low = a[1:0];
      if (ALIGN && low != 2'b00)
         return mk(rd, wr, a, wd, lat, rdat, 1, 0, 1, prev);
      else if (lat <= int'(TO))
         return mk(rd, wr, a, wd, lat, rdat, lat + 1, lat, 0, wr ? prev : rdat);
      else
         return mk(rd, wr, a, wd, lat, rdat, TO + 1, TO, 1, prev);
   endfunction

   // Called #1 after a posedge with the unit idle; returns the same way.
   task automatic run_access(input vec_t v, input string tag);
      logic [31:0] a0, w0, mdr_act;
      logic        we0;
      bit          unstable, req_in_done, done;
      int          sc, rc, ec;
      a0 = '0; w0 = '0; we0 = 1'b0; mdr_act = '0;
      unstable = 0; req_in_done = 0; done = 0;
      sc = 0; rc = 0; ec = 0;
      mem_read = v.rd; mem_write = v.wr; addr = v.a; wdata = v.wd;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (err) ec++;
         if (!stall) begin
            done    = 1;
            mdr_act = mdr;
            if (bus_if.bus_req) req_in_done = 1;
         end else begin
            sc++;
            if (bus_if.bus_req) begin
               rc++;
               if (rc == 1) begin
                  a0 = bus_if.bus_addr; w0 = bus_if.bus_wdata; we0 = bus_if.bus_we;
               end else if (a0 !== bus_if.bus_addr || w0 !== bus_if.bus_wdata || we0 !== bus_if.bus_we) begin
                  unstable = 1;
               end
               if (rc == v.lat) begin
                  bus_if.bus_rdata = v.rdat;
                  bus_if.bus_ack   = 1'b1;
               end
            end
         end
         @(posedge clk); #1;
         bus_if.bus_ack = 1'b0;
      end
      if (!done) check({tag, " done_reached"}, 0, 1);
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      if (err) ec++;
      @(posedge clk); #1;
      check({tag, " stall_cycles"}, sc, v.exp_stall);
      check({tag, " req_cycles"},   rc, v.exp_req);
      check({tag, " err_pulses"},   ec, v.exp_err);
      check({tag, " mdr"},          mdr_act, v.exp_mdr);
      check({tag, " req_in_done"},  req_in_done, 0);
      if (v.exp_req > 0) begin
         check({tag, " bus_we"},    we0, v.wr);
         check({tag, " bus_addr"},  a0, v.a & ~32'h3);
         check({tag, " bus_wdata"}, w0, v.wd);
         check({tag, " bus_stable"}, unstable, 0);
      end
      mdr_model = v.exp_mdr;
   endtask

   initial begin
      vec_t v;
      int   k;
      logic [31:0] ra;

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
      mdr_model = '0;

      vecs[0] = mk(1, 0, 32'h40,  32'h0,        1,  32'h1234_5678, 2,  1,  0, 32'h1234_5678);
      vecs[1] = mk(0, 1, 32'h80,  32'hCAFE_F00D, 4,  32'hFFFF_FFFF, 5,  4,  0, 32'h1234_5678);
      vecs[2] = mk(1, 0, 32'h100, 32'h0,        99, 32'h0,         16, 15, 1, 32'h1234_5678);
      vecs[3] = mk(1, 1, 32'h10,  32'h1111_2222, 2,  32'hDEAD_BEEF, 3,  2,  0, 32'h1234_5678);
      vecs[4] = ALIGN ? mk(1, 0, 32'h42, 32'h0, 3, 32'hA5A5_A5A5, 1, 0, 1, 32'h1234_5678)
                      : mk(1, 0, 32'h42, 32'h0, 3, 32'hA5A5_A5A5, 4, 3, 0, 32'hA5A5_A5A5);
      vecs[5] = mk(1, 0, 32'h20,  32'h0,        15, 32'h0BAD_F00D, 16, 15, 0, 32'h0BAD_F00D);
      vecs[6] = mk(0, 1, 32'h7FC, 32'h0102_0304, 1,  32'h0,         2,  1,  0, 32'h0BAD_F00D);

      #12 rst = 1'b0;
      @(negedge clk);
      check("reset bus_req",   bus_if.bus_req, 0);
      check("reset bus_we",    bus_if.bus_we, 0);
      check("reset bus_addr",  bus_if.bus_addr, 0);
      check("reset bus_wdata", bus_if.bus_wdata, 0);
      check("reset mdr",       mdr, 0);
      check("reset err",       err, 0);
      check("reset stall",     stall, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_access(vecs[i], $sformatf("vec%0d", i));

      // ack while idle must be ignored
      bus_if.bus_rdata = 32'hFFFF_FFFF;
      bus_if.bus_ack   = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      check("idle_ack mdr",     mdr, mdr_model);
      check("idle_ack bus_req", bus_if.bus_req, 0);

      // strobe dropped mid-access: access still completes
      mem_read = 1'b1; addr = 32'h200;
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("drop bus_req_held", bus_if.bus_req, 1);
      bus_if.bus_rdata = 32'h5555_AAAA;
      bus_if.bus_ack   = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      check("drop mdr",     mdr, 32'h5555_AAAA);
      check("drop bus_req", bus_if.bus_req, 0);
      @(posedge clk); #1;
      mdr_model = 32'h5555_AAAA;

      // asynchronous reset in the middle of a bus cycle
      mem_write = 1'b1; addr = 32'h300; wdata = 32'h7777_8888;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst bus_req", bus_if.bus_req, 1);
      #2 rst = 1'b1;
      #1;
      check("rst bus_req",   bus_if.bus_req, 0);
      check("rst bus_we",    bus_if.bus_we, 0);
      check("rst bus_addr",  bus_if.bus_addr, 0);
      check("rst bus_wdata", bus_if.bus_wdata, 0);
      check("rst mdr",       mdr, 0);
      check("rst err",       err, 0);
      mem_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      mdr_model = '0;
      run_access(predict(1, 0, 32'h44, 32'h0, 2, 32'h600D_CAFE, mdr_model), "post_rst");

      for (int i = 0; i < 40; i++) begin
         k  = $urandom_range(1, 3);
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra = ra & ~32'h3;
         v = predict(k[0], k[1], ra, $urandom, $urandom_range(1, TO + 3), $urandom, mdr_model);
         run_access(v, $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
